// File: rtl/axis_width_conv_pkt.sv
// axis_width_conv_pkt: packet-aware N-to-M bit repacker over an MSB-aligned bit buffer
module axis_width_conv_pkt #(
  parameter int N = 8,
  parameter int M = 5,
  parameter int BUF_W = 2*(N+M),
  parameter int CNT_W = $clog2(BUF_W+1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             s_axis_tnext,
  input  logic [N-1:0]     s_axis_tdata,
  input  logic             s_axis_tfirst,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  input  logic             m_axis_tnext,
  output logic [M-1:0]     m_axis_tdata,
  output logic             m_axis_tfirst,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  output logic [CNT_W-1:0] bit_count
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d, shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_rem;
  logic first_q, first_d;
  logic implicit_flush, acc, emit, m_valid;
  logic [31:0] cnt_w;
  always_comb begin
    cnt_w = 32'(cnt_q);
    implicit_flush = s_axis_tvalid & s_axis_tfirst & (cnt_q != '0) & (state_q == RUN);
    acc = ~rst & s_axis_tvalid & (state_q == RUN) & (cnt_w + 32'(N) <= 32'(BUF_W)) & ~implicit_flush;
    m_valid = ~rst & ((cnt_w >= 32'(M)) | ((state_q == FLUSH) & (cnt_q != '0)));
    emit = m_valid & m_axis_tnext;
    shifted = emit ? buf_q << M : buf_q;
    cnt_rem = emit ? ((cnt_w >= 32'(M)) ? cnt_q - CNT_W'(M) : '0) : cnt_q;
    // new bits land directly below whatever survives this cycle's emit
    buf_d = acc ? shifted | ({s_axis_tdata, {(BUF_W-N){1'b0}}} >> cnt_rem) : shifted;
    cnt_d = acc ? cnt_rem + CNT_W'(N) : cnt_rem;
    first_d = (acc & s_axis_tfirst) | (first_q & ~emit);
    state_d = (state_q == RUN) ? (((acc & s_axis_tlast) | implicit_flush) ? FLUSH : RUN)
                               : ((emit & (cnt_rem == '0)) ? RUN : FLUSH);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      buf_q <= '0;
      cnt_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      first_q <= first_d;
    end
  end
  assign s_axis_tnext = acc;
  assign m_axis_tvalid = m_valid;
  assign m_axis_tdata = rst ? '0 : buf_q[BUF_W-1 -: M];
  assign m_axis_tfirst = first_q & m_valid;
  assign m_axis_tlast = (state_q == FLUSH) & (cnt_w <= 32'(M)) & m_valid;
  assign bit_count = cnt_q;
endmodule

// File: tb/tb_axis_width_conv_pkt.sv
// tb_axis_width_conv_pkt: directed checks of the packet-aware width converter (8->5 and 5->8)
module tb_axis_width_conv_pkt;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic s_tnext, s_tfirst, s_tlast, s_tvalid, m_tnext, m_tfirst, m_tlast, m_tvalid;
  logic [7:0] s_tdata;
  logic [4:0] m_tdata, cnt;
  logic b_s_tnext, b_s_tfirst, b_s_tlast, b_s_tvalid, b_m_tnext, b_m_tfirst, b_m_tlast, b_m_tvalid;
  logic [4:0] b_s_tdata, b_cnt;
  logic [7:0] b_m_tdata;

  axis_width_conv_pkt #(.N(8), .M(5)) dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tnext(s_tnext), .s_axis_tdata(s_tdata), .s_axis_tfirst(s_tfirst),
    .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .m_axis_tnext(m_tnext), .m_axis_tdata(m_tdata), .m_axis_tfirst(m_tfirst),
    .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .bit_count(cnt)
  );

  axis_width_conv_pkt #(.N(5), .M(8), .BUF_W(26)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tnext(b_s_tnext), .s_axis_tdata(b_s_tdata), .s_axis_tfirst(b_s_tfirst),
    .s_axis_tlast(b_s_tlast), .s_axis_tvalid(b_s_tvalid),
    .m_axis_tnext(b_m_tnext), .m_axis_tdata(b_m_tdata), .m_axis_tfirst(b_m_tfirst),
    .m_axis_tlast(b_m_tlast), .m_axis_tvalid(b_m_tvalid), .bit_count(b_cnt)
  );

  typedef struct packed {logic [7:0] d; logic f; logic l;} wd_t;
  wd_t src[$];
  wd_t outq[$];
  int acc_at[$];
  int out_at[$];
  int sp, cyc, pass_n, fail_n, total_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    src.delete();
    outq.delete();
    acc_at.delete();
    out_at.delete();
    sp = 0;
  endtask

  task automatic push(input logic [7:0] d, input logic f, input logic l);
    src.push_back(wd_t'{d: d, f: f, l: l});
  endtask

  task automatic cycle();
    s_tvalid = sp < src.size();
    s_tdata  = s_tvalid ? src[sp].d : 8'h00;
    s_tfirst = s_tvalid ? src[sp].f : 1'b0;
    s_tlast  = s_tvalid ? src[sp].l : 1'b0;
    #1;
    if (m_tvalid && m_tnext) begin
      outq.push_back(wd_t'{d: 8'(m_tdata), f: m_tfirst, l: m_tlast});
      out_at.push_back(cyc);
    end
    if (s_tnext) begin
      acc_at.push_back(cyc);
      sp++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic chk_out(input string tag, input int k, input logic [7:0] d, input logic f, input logic l);
    chk($sformatf("%s_out%0d", tag, k), {22'd0, outq[k].d, outq[k].f, outq[k].l}, {22'd0, d, f, l});
  endtask

  logic [7:0] exp4 [8];
  logic [199:0] ref_bits;
  wd_t bout[$];
  int chg, bi, a0, al, maxc;

  initial begin
    pass_n = 0; fail_n = 0; total_n = 0; cyc = 0;
    clear();
    m_tnext = 1'b1;
    b_m_tnext = 1'b1;
    b_s_tvalid = 1'b0; b_s_tdata = '0; b_s_tfirst = 1'b0; b_s_tlast = 1'b0;
    s_tvalid = 1'b1; s_tdata = 8'hFF; s_tfirst = 1'b0; s_tlast = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_s_tnext", 32'(s_tnext), 0);
    chk("rst_m_tvalid", 32'(m_tvalid), 0);
    chk("rst_m_tdata", 32'(m_tdata), 0);
    chk("rst_bit_count", 32'(cnt), 0);
    rst = 1'b0;

    // 1: five 0xFF bytes -> eight 0x1F words
    clear();
    for (int i = 0; i < 5; i++) push(8'hFF, i == 0, i == 4);
    run(14);
    chk("t1_nout", outq.size(), 8);
    for (int k = 0; k < 8; k++) chk_out("t1", k, 8'h1F, k == 0, k == 7);
    chk("t1_bit_count", 32'(cnt), 0);

    // 2: single 0xB4 first+last, then a second packet waits out the flush
    clear();
    push(8'hB4, 1'b1, 1'b1);
    push(8'hFF, 1'b1, 1'b1);
    run(8);
    chk("t2_nout", outq.size(), 4);
    chk_out("t2", 0, 8'h16, 1'b1, 1'b0);
    chk_out("t2", 1, 8'h10, 1'b0, 1'b1);
    chk_out("t2", 2, 8'h1F, 1'b1, 1'b0);
    chk_out("t2", 3, 8'h1C, 1'b0, 1'b1);
    chk("t2_accept_gap", 32'(acc_at[1] - acc_at[0]), 3);

    // 3: implicit flush
    clear();
    push(8'h80, 1'b1, 1'b0);
    push(8'hFF, 1'b1, 1'b1);
    run(8);
    chk("t3_nout", outq.size(), 4);
    chk_out("t3", 0, 8'h10, 1'b1, 1'b0);
    chk_out("t3", 1, 8'h00, 1'b0, 1'b1);
    chk_out("t3", 2, 8'h1F, 1'b1, 1'b0);
    chk_out("t3", 3, 8'h1C, 1'b0, 1'b1);
    chk("t3_pop_after_flush", 32'(acc_at[1]), 32'(out_at[1] + 1));

    // 4: backpressure
    clear();
    m_tnext = 1'b0;
    for (int i = 0; i < 64; i++) push(8'hA0 + 8'(i), i == 0, 1'b0);
    chg = 0;
    repeat (66) begin
      cycle();
      if (m_tvalid && m_tdata !== 5'h14) chg++;
    end
    chk("t4_accepts", acc_at.size(), 3);
    chk("t4_bit_count", 32'(cnt), 24);
    chk("t4_m_tvalid", 32'(m_tvalid), 1);
    chk("t4_m_tdata", 32'(m_tdata), 32'h14);
    chk("t4_frozen", chg, 0);
    src = src[0:4];
    src[4].l = 1'b1;
    m_tnext = 1'b1;
    run(15);
    exp4 = '{8'h14, 8'h02, 8'h10, 8'h1A, 8'h05, 8'h08, 8'h1D, 8'h04};
    chk("t4_nout", outq.size(), 8);
    for (int k = 0; k < 8; k++) chk_out("t4", k, exp4[k], k == 0, k == 7);

    // 6: reset mid-packet
    clear();
    for (int i = 0; i < 6; i++) push(8'h33, i == 0, 1'b0);
    run(8);
    chk("t6_pre_bit_count", 32'(cnt), 13);
    rst = 1'b1;
    #1;
    chk("t6_rst_m_tvalid", 32'(m_tvalid), 0);
    chk("t6_rst_m_tdata", 32'(m_tdata), 0);
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
    chk("t6_post_bit_count", 32'(cnt), 0);
    chk("t6_post_m_tvalid", 32'(m_tvalid), 0);
    clear();
    push(8'h5A, 1'b1, 1'b1);
    run(6);
    chk("t6_nout", outq.size(), 2);
    chk_out("t6", 0, 8'h0B, 1'b1, 1'b0);
    chk_out("t6", 1, 8'h08, 1'b0, 1'b1);

    // 5: N=5, M=8 continuous stream
    for (int i = 0; i < 40; i++) ref_bits[199-5*i -: 5] = 5'(i*7+3);
    bi = 0; a0 = -1; al = -1; maxc = 0;
    repeat (70) begin
      b_s_tvalid = bi < 40;
      b_s_tdata  = 5'(bi*7+3);
      b_s_tfirst = bi == 0;
      b_s_tlast  = bi == 39;
      #1;
      if (b_m_tvalid && b_m_tnext) bout.push_back(wd_t'{d: b_m_tdata, f: b_m_tfirst, l: b_m_tlast});
      if (b_s_tnext) begin
        if (bi == 0) a0 = cyc;
        al = cyc;
        bi++;
      end
      if (int'(b_cnt) > maxc) maxc = int'(b_cnt);
      @(posedge clk); #1;
      cyc++;
    end
    chk("t5_accepts", bi, 40);
    chk("t5_accept_span", 32'(al - a0), 39);
    chk("t5_nout", bout.size(), 25);
    chk("t5_max_bit_count_le21", 32'(maxc <= 21), 1);
    for (int k = 0; k < 25; k++)
      chk($sformatf("t5_out%0d", k), {22'd0, bout[k].d, bout[k].f, bout[k].l},
          {22'd0, ref_bits[199-8*k -: 8], 1'(k == 0), 1'(k == 24)});

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
